deint_sched: RTL
================

Name: deint_sched

Overview:
- Per-packet sequencer for the OFDM RX deinterleaver. It sits between the equalizer/demapper output and the deinterleaver input.
- Drives the deinterleaver's rate, enable, reset and input_strobe, and applies backpressure to upstream while the deinterleaver drains a symbol.
- Sequences one SIGNAL symbol at the fixed legacy BPSK rate, then N data symbols at the decoded rate. Flags overrun, bad-rate and drain-timeout errors.

Parameters:
- SIG_RATE, 8'h0B, rate code used for the SIGNAL symbol (legacy, BPSK 1/2).
- DRAIN_TIMEOUT, 255, maximum cycles allowed in a drain state before abort.
- SYM_CNT_W, 16, width of the data-symbol counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global enable; when low, all state holds and deint_enable=0
- pkt_start  in  1  single-cycle pulse: new packet detected
- data_rate_valid  in  1  pulse: data_rate and num_data_sym valid (from the SIGNAL/HT-SIG parser)
- data_rate  in  8  data rate code; bit7=HT, [3:0]=MCS/legacy code
- num_data_sym  in  SYM_CNT_W  number of data symbols in the packet
- carrier_strobe  in  1  one demapped carrier available upstream
- carrier_ready  out  1  upstream may present carriers
- deint_enable  out  1  deinterleaver enable
- deint_reset  out  1  deinterleaver reset
- deint_rate  out  8  deinterleaver rate
- deint_input_strobe  out  1  write strobe to the deinterleaver
- deint_output_strobe  in  1  deinterleaver output pair strobe
- sym_done  out  1  pulse: one symbol fully drained
- pkt_done  out  1  pulse: last data symbol drained
- err  out  3  sticky error bits: {timeout, bad_rate, overrun}; cleared on pkt_start

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, carrier_ready=0, deint_enable=0, deint_reset=1 while reset is high, deint_rate=SIG_RATE, sym_done=0, pkt_done=0, err=0, all counters 0.
- Carrier count per symbol NC: 48 if rate[7]=0, else 52.
- Output pair target PT = NCBPS/2:
  - legacy BPSK/QPSK/16QAM/64QAM: 24/48/96/144.
  - HT: 26/52/104/156.
  - Computed from {rate[7],rate[3:0]} using the deinterleaver's modulation classes.
- deint_input_strobe = carrier_strobe & carrier_ready & enable. This is combinational, zero latency.
- carrier_strobe while carrier_ready=0 sets err[0] (overrun). The strobe is dropped, not forwarded.
- deint_enable = enable in every state except IDLE.
- States and transitions:
  - IDLE: carrier_ready=0. On pkt_start: deint_rate<=SIG_RATE, clear err, go to RST_SIG.
  - RST_SIG: deint_reset=1 for exactly 1 cycle, with deint_rate already stable. Then go to SIG_IN.
  - SIG_IN: carrier_ready=1. Count forwarded strobes. At count NC-1 plus a strobe: carrier_ready drops on the next cycle, go to SIG_DRAIN.
  - SIG_DRAIN: count deint_output_strobe. At PT: pulse sym_done, go to WAIT_RATE.
  - WAIT_RATE: on data_rate_valid:
    - If the rate is in no modulation class: set err[1], go to IDLE.
    - Else if num_data_sym=0: pulse pkt_done, go to IDLE.
    - Else latch deint_rate<=data_rate and the symbol count, go to RST_DATA.
  - RST_DATA: 1-cycle deint_reset (the deinterleaver reloads its base address from the new HT bit), go to DATA_IN.
  - DATA_IN and DATA_DRAIN: same as SIG_IN and SIG_DRAIN, using the latched rate.
  - On drain complete: pulse sym_done and decrement the symbol counter.
    - If the counter was 1: also pulse pkt_done, go to IDLE.
    - Else go to DATA_IN. There is no deint_reset between data symbols; the deinterleaver self-wraps.
- Drain timer:
  - Counts cycles in SIG_DRAIN/DATA_DRAIN while enable=1.
  - At DRAIN_TIMEOUT: set err[2], pulse deint_reset for 1 cycle, go to IDLE.
  - The timer clears on entry to each drain state.
- pkt_start in any non-IDLE state aborts the current packet. Counters clear and the FSM goes to RST_SIG; pkt_done is not pulsed.
- enable=0: FSM, counters and the timer freeze. Strobes arriving during this time are ignored.
- Simultaneous carrier_strobe on the cycle of the NC-th write: the strobe is accepted. carrier_ready is low from the next cycle.
- deint_output_strobe outside the drain states is ignored.

Decomposition:
- Shared package ofdm_rx_pkg holds:
  - the rate-code constants (legacy 4-bit codes, HT MCS codes);
  - the NC constants 48/52;
  - a function returning n_bpsc_div2 (0..3, or invalid);
  - a function returning PT from the rate code;
  - the state enum.
- One sub-module: deint_rate_decode (combinational: rate in, outputs valid, NC and PT), reused by the demapper control.

Test Plan:
- Legacy 6 Mb/s, num_data_sym=2:
  - pkt_start, then 48 carriers, then 24 output strobes gives sym_done.
  - Rate 8'h0B, then 48 carriers / 24 strobes twice gives 3 sym_done pulses, pkt_done on the last, and err=0.
- HT MCS7 (rate 8'h97), 1 symbol:
  - deint_reset pulses in RST_DATA with deint_rate=8'h97.
  - carrier_ready drops after 52 carriers; 156 output strobes are required before pkt_done.
- Overrun: carrier_strobe during SIG_DRAIN gives err=3'b001, no deint_input_strobe, and the FSM is unaffected.
- Bad rate 8'h05 on data_rate_valid gives err=3'b010, return to IDLE, no pkt_done.
- Timeout: SIG_DRAIN with only 10 output strobes for 255 cycles gives err=3'b100, a 1-cycle deint_reset, and IDLE.
- Mid-packet pkt_start during DATA_IN gives a 1-cycle deint_reset, deint_rate=8'h0B, counters cleared, and err cleared.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM RX definitions: rate codes, carrier counts, modulation
// classification helpers and the deinterleaver scheduler state type.
package ofdm_rx_pkg;

  // Legacy 802.11a 4-bit RATE field codes
  localparam logic [3:0] RATE_6M  = 4'hB;
  localparam logic [3:0] RATE_9M  = 4'hF;
  localparam logic [3:0] RATE_12M = 4'hA;
  localparam logic [3:0] RATE_18M = 4'hE;
  localparam logic [3:0] RATE_24M = 4'h9;
  localparam logic [3:0] RATE_36M = 4'hD;
  localparam logic [3:0] RATE_48M = 4'h8;
  localparam logic [3:0] RATE_54M = 4'hC;

  // Single-stream HT MCS codes
  localparam logic [3:0] MCS0 = 4'd0;
  localparam logic [3:0] MCS1 = 4'd1;
  localparam logic [3:0] MCS2 = 4'd2;
  localparam logic [3:0] MCS3 = 4'd3;
  localparam logic [3:0] MCS4 = 4'd4;
  localparam logic [3:0] MCS5 = 4'd5;
  localparam logic [3:0] MCS6 = 4'd6;
  localparam logic [3:0] MCS7 = 4'd7;

  // Legacy BPSK 1/2 rate used for the SIGNAL symbol
  localparam logic [7:0] SIG_RATE_LEGACY = 8'h0B;

  // Data carriers per symbol
  localparam logic [5:0] NC_LEGACY = 6'd48;
  localparam logic [5:0] NC_HT     = 6'd52;

  // Modulation class, numerically equal to the class index 0..3
  typedef enum logic [2:0] {
    MOD_BPSK    = 3'd0,
    MOD_QPSK    = 3'd1,
    MOD_16QAM   = 3'd2,
    MOD_64QAM   = 3'd3,
    MOD_INVALID = 3'd4
  } mod_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_SIG,
    ST_SIG_IN,
    ST_SIG_DRAIN,
    ST_WAIT_RATE,
    ST_RST_DATA,
    ST_DATA_IN,
    ST_DATA_DRAIN
  } sched_state_t;

  // Map {ht, code} to the deinterleaver's modulation class
  function automatic mod_class_t n_bpsc_div2(input logic ht, input logic [3:0] code);
    mod_class_t m;
    m = MOD_INVALID;
    if (ht) begin
      case (code)
        MCS0:             m = MOD_BPSK;
        MCS1, MCS2:       m = MOD_QPSK;
        MCS3, MCS4:       m = MOD_16QAM;
        MCS5, MCS6, MCS7: m = MOD_64QAM;
        default:          m = MOD_INVALID;
      endcase
    end else begin
      case (code)
        RATE_6M,  RATE_9M:  m = MOD_BPSK;
        RATE_12M, RATE_18M: m = MOD_QPSK;
        RATE_24M, RATE_36M: m = MOD_16QAM;
        RATE_48M, RATE_54M: m = MOD_64QAM;
        default:            m = MOD_INVALID;
      endcase
    end
    return m;
  endfunction

  // Output pairs per symbol (NCBPS/2); zero for an unknown rate
  function automatic logic [7:0] pair_target(input logic ht, input logic [3:0] code);
    logic [7:0] base;
    logic [7:0] pt;
    base = ht ? 8'd26 : 8'd24;
    case (n_bpsc_div2(ht, code))
      MOD_BPSK:  pt = base;
      MOD_QPSK:  pt = base << 1;
      MOD_16QAM: pt = base << 2;
      MOD_64QAM: pt = (base << 2) + (base << 1);
      default:   pt = 8'd0;
    endcase
    return pt;
  endfunction

endpackage

// File: rtl/deint_sched_if.sv
// Deinterleaver control bus: the scheduler masters it, the deinterleaver
// answers with its output-pair strobe.
interface deint_sched_if;
  logic       deint_enable;
  logic       deint_reset;
  logic [7:0] deint_rate;
  logic       deint_input_strobe;
  logic       deint_output_strobe;

  modport master (
    output deint_enable,
    output deint_reset,
    output deint_rate,
    output deint_input_strobe,
    input  deint_output_strobe
  );

  modport slave (
    input  deint_enable,
    input  deint_reset,
    input  deint_rate,
    input  deint_input_strobe,
    output deint_output_strobe
  );
endinterface

// File: rtl/deint_rate_decode.sv
// Combinational rate decoder: validity, carriers per symbol and output-pair
// target. Shared with the demapper control.
module deint_rate_decode
  import ofdm_rx_pkg::*;
(
  input  logic [7:0] rate,
  output logic       valid,
  output logic [5:0] nc,
  output logic [7:0] pt
);

  // Bits [6:4] carry no information for the deinterleaver
  logic unused_rate_bits;
  assign unused_rate_bits = ^rate[6:4];

  // Classify the rate and derive the per-symbol counts
  always_comb begin
    valid = (n_bpsc_div2(rate[7], rate[3:0]) != MOD_INVALID);
    nc    = rate[7] ? NC_HT : NC_LEGACY;
    pt    = pair_target(rate[7], rate[3:0]);
  end

endmodule

// File: rtl/deint_sched.sv
// Per-packet deinterleaver sequencer: one SIGNAL symbol at the legacy rate,
// then N data symbols at the decoded rate, with backpressure while draining.
module deint_sched
  import ofdm_rx_pkg::*;
#(
  parameter logic [7:0] SIG_RATE      = SIG_RATE_LEGACY,
  parameter int         DRAIN_TIMEOUT = 255,
  parameter int         SYM_CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pkt_start,
  input  logic                 data_rate_valid,
  input  logic [7:0]           data_rate,
  input  logic [SYM_CNT_W-1:0] num_data_sym,
  input  logic                 carrier_strobe,
  output logic                 carrier_ready,
  deint_sched_if.master        deint,
  output logic                 sym_done,
  output logic                 pkt_done,
  output logic [2:0]           err
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

  sched_state_t         state, state_n;
  logic [5:0]           car_cnt, car_cnt_n;
  logic [7:0]           out_cnt, out_cnt_n;
  logic [TMR_W-1:0]     tmr, tmr_n;
  logic [SYM_CNT_W-1:0] sym_cnt, sym_cnt_n;
  logic [7:0]           rate_q, rate_n;
  logic [2:0]           err_n;
  logic                 sym_done_n, pkt_done_n;
  logic                 abort_rst, abort_rst_n;

  logic       cur_valid_unused;
  logic [5:0] cur_nc;
  logic [7:0] cur_pt;
  logic       new_valid;
  logic [5:0] new_nc_unused;
  logic [7:0] new_pt_unused;

  // Counts for the rate currently programmed into the deinterleaver
  deint_rate_decode u_cur_decode (
    .rate  (rate_q),
    .valid (cur_valid_unused),
    .nc    (cur_nc),
    .pt    (cur_pt)
  );

  // Validity of the rate offered by the SIGNAL/HT-SIG parser
  deint_rate_decode u_new_decode (
    .rate  (data_rate),
    .valid (new_valid),
    .nc    (new_nc_unused),
    .pt    (new_pt_unused)
  );

  assign carrier_ready            = (state == ST_SIG_IN) || (state == ST_DATA_IN);
  assign deint.deint_input_strobe = carrier_strobe & carrier_ready & enable;
  assign deint.deint_enable       = enable && (state != ST_IDLE);
  assign deint.deint_reset        = reset || abort_rst ||
                                    (state == ST_RST_SIG) || (state == ST_RST_DATA);
  assign deint.deint_rate         = rate_q;

  // Next-state, counter and pulse logic; everything holds while enable is low
  always_comb begin
    state_n     = state;
    car_cnt_n   = car_cnt;
    out_cnt_n   = out_cnt;
    tmr_n       = tmr;
    sym_cnt_n   = sym_cnt;
    rate_n      = rate_q;
    err_n       = err;
    sym_done_n  = 1'b0;
    pkt_done_n  = 1'b0;
    abort_rst_n = 1'b0;
    if (enable) begin
      if (carrier_strobe && !carrier_ready) err_n[0] = 1'b1;
      if (pkt_start) begin
        state_n   = ST_RST_SIG;
        car_cnt_n = '0;
        out_cnt_n = '0;
        tmr_n     = '0;
        sym_cnt_n = '0;
        rate_n    = SIG_RATE;
        err_n     = 3'b000;
      end else begin
        case (state)
          ST_IDLE: state_n = ST_IDLE;
          ST_RST_SIG: state_n = ST_SIG_IN;
          ST_RST_DATA: state_n = ST_DATA_IN;
          ST_SIG_IN, ST_DATA_IN: begin
            if (deint.deint_input_strobe) begin
              if (car_cnt == cur_nc - 6'd1) begin
                car_cnt_n = '0;
                out_cnt_n = '0;
                tmr_n     = '0;
                state_n   = (state == ST_SIG_IN) ? ST_SIG_DRAIN : ST_DATA_DRAIN;
              end else begin
                car_cnt_n = car_cnt + 6'd1;
              end
            end
          end
          ST_SIG_DRAIN, ST_DATA_DRAIN: begin
            if (deint.deint_output_strobe && (out_cnt == cur_pt - 8'd1)) begin
              out_cnt_n  = '0;
              tmr_n      = '0;
              sym_done_n = 1'b1;
              if (state == ST_SIG_DRAIN) begin
                state_n = ST_WAIT_RATE;
              end else begin
                sym_cnt_n = sym_cnt - SYM_CNT_W'(1);
                if (sym_cnt == SYM_CNT_W'(1)) begin
                  pkt_done_n = 1'b1;
                  state_n    = ST_IDLE;
                end else begin
                  state_n = ST_DATA_IN;
                end
              end
            end else if (tmr == TMR_LAST) begin
              err_n[2]    = 1'b1;
              abort_rst_n = 1'b1;
              out_cnt_n   = '0;
              tmr_n       = '0;
              state_n     = ST_IDLE;
            end else begin
              tmr_n = tmr + TMR_W'(1);
              if (deint.deint_output_strobe) out_cnt_n = out_cnt + 8'd1;
            end
          end
          ST_WAIT_RATE: begin
            if (data_rate_valid) begin
              if (!new_valid) begin
                err_n[1] = 1'b1;
                state_n  = ST_IDLE;
              end else if (num_data_sym == '0) begin
                pkt_done_n = 1'b1;
                state_n    = ST_IDLE;
              end else begin
                rate_n    = data_rate;
                sym_cnt_n = num_data_sym;
                state_n   = ST_RST_DATA;
              end
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      car_cnt   <= '0;
      out_cnt   <= '0;
      tmr       <= '0;
      sym_cnt   <= '0;
      rate_q    <= SIG_RATE;
      err       <= 3'b000;
      sym_done  <= 1'b0;
      pkt_done  <= 1'b0;
      abort_rst <= 1'b0;
    end else begin
      state     <= state_n;
      car_cnt   <= car_cnt_n;
      out_cnt   <= out_cnt_n;
      tmr       <= tmr_n;
      sym_cnt   <= sym_cnt_n;
      rate_q    <= rate_n;
      err       <= err_n;
      sym_done  <= sym_done_n;
      pkt_done  <= pkt_done_n;
      abort_rst <= abort_rst_n;
    end
  end

endmodule
